// File: rtl/demux4x32_buf.sv
// demux4x32_buf: fans one producer out to four consumers.
// Each accepted word goes to the channel picked by S and waits there in a
// 2-entry FIFO until that consumer takes it.
//
// Handshake (valid/ready, both sides):
//   - Input: a word transfers on a rising edge when IV && IR. IR is computed
//     only from S, R and the stored state, never from IV. A producer that sees
//     IR=0 keeps D, S and IV unchanged until IR=1.
//   - Output k: the head word Yk transfers on a rising edge when V[k] && R[k].
//     R[k] while V[k]=0 is ignored. Yk stays stable while V[k] && !R[k].
module demux4x32_buf #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] D,
    input  logic [1:0]   S,
    input  logic         IV,
    output logic         IR,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic [3:0]   V,
    input  logic [3:0]   R,
    output logic [3:0]   FULL,
    output logic         ACC
);

    localparam logic [1:0] OCC_MAX = 2'(DEPTH);

    // Per-channel storage. The pointers are a single bit because each FIFO
    // holds exactly two entries.
    logic [W-1:0] mem [4][2];
    logic [3:0]   wp;
    logic [3:0]   rp;
    logic [1:0]   occ [4];

    logic [3:0]   push;
    logic [3:0]   pop;
    logic         ir_int;
    logic         acc_q;

    // Channel status flags and the independent per-channel pop qualifiers.
    always_comb begin
        V    = 4'b0000;
        FULL = 4'b0000;
        pop  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            V[k]    = (occ[k] != 2'd0);
            FULL[k] = (occ[k] == OCC_MAX);
            pop[k]  = V[k] && R[k];
        end
    end

    // Input ready: the selected channel has room, or it frees a slot this
    // same cycle. Only the channel selected by S can be pushed.
    always_comb begin
        ir_int = !FULL[S] || pop[S];
        push   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            push[k] = IV && ir_int && (S == 2'(k));
        end
    end

    assign IR  = ir_int;
    assign ACC = acc_q;

    // The head word of each channel comes from storage, so there is no path
    // from D to any Yk.
    assign Y0 = mem[0][rp[0]];
    assign Y1 = mem[1][rp[1]];
    assign Y2 = mem[2][rp[2]];
    assign Y3 = mem[3][rp[3]];

    // FIFO state update. Reset wins over any push or pop in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wp    <= 4'b0000;
            rp    <= 4'b0000;
            acc_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                occ[k]    <= 2'd0;
                mem[k][0] <= '0;
                mem[k][1] <= '0;
            end
        end else begin
            acc_q <= IV && ir_int;
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    mem[k][wp[k]] <= D;
                    wp[k]         <= ~wp[k];
                end
                if (pop[k]) begin
                    rp[k] <= ~rp[k];
                end
                occ[k] <= occ[k] + {1'b0, push[k]} - {1'b0, pop[k]};
            end
        end
    end

endmodule

// File: tb/tb_demux4x32_buf.sv
// Bench for demux4x32_buf: table of directed vectors followed by hand-written
// sequences for draining all channels and reset during a push.
module tb_demux4x32_buf;

    logic        clk;
    logic        rst;
    logic [31:0] d;
    logic [1:0]  s;
    logic        iv;
    logic        ir;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  v;
    logic [3:0]  r;
    logic [3:0]  full;
    logic        acc;

    int checks = 0;
    int errors = 0;

    demux4x32_buf #(.W(32), .DEPTH(2)) dut (
        .CLK  (clk),
        .RST  (rst),
        .D    (d),
        .S    (s),
        .IV   (iv),
        .IR   (ir),
        .Y0   (y0),
        .Y1   (y1),
        .Y2   (y2),
        .Y3   (y3),
        .V    (v),
        .R    (r),
        .FULL (full),
        .ACC  (acc)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic [1:0]  s;
        logic [31:0] d;
        logic [3:0]  r;
        logic        chk_ir;
        logic        e_ir;
        logic [3:0]  e_v;
        logic [3:0]  e_full;
        logic        e_acc;
        logic [31:0] e_y0;
        logic [31:0] e_y1;
        logic [31:0] e_y2;
        logic [31:0] e_y3;
    } vec_t;

    vec_t tbl [16];
    int   n_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_y(input int k);
        case (k)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    function automatic logic [31:0] wd(input int k, input int i);
        return 32'hC000_0000 | 32'(k << 4) | 32'(i);
    endfunction

    task automatic add(input logic rst_i, input logic iv_i, input logic [1:0] s_i,
                       input logic [31:0] d_i, input logic [3:0] r_i,
                       input logic chk_ir_i, input logic e_ir_i,
                       input logic [3:0] e_v_i, input logic [3:0] e_full_i,
                       input logic e_acc_i, input logic [31:0] e_y0_i,
                       input logic [31:0] e_y1_i, input logic [31:0] e_y2_i,
                       input logic [31:0] e_y3_i);
        tbl[n_vec] = '{rst_i, iv_i, s_i, d_i, r_i, chk_ir_i, e_ir_i, e_v_i,
                       e_full_i, e_acc_i, e_y0_i, e_y1_i, e_y2_i, e_y3_i};
        n_vec++;
    endtask

    // Driver: push one word, waiting a bounded number of cycles for IR.
    task automatic push_word(input logic [31:0] dw, input logic [1:0] sel);
        int waited;
        rst = 1'b0;
        iv  = 1'b1;
        d   = dw;
        s   = sel;
        r   = 4'b0000;
        waited = 0;
        #1;
        while (ir !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("push_ready", 32'(ir), 32'd1);
        @(posedge clk);
        #1;
        chk("push_acc", 32'(acc), 32'd1);
        iv = 1'b0;
    endtask

    task automatic idle_cycle(input logic [3:0] r_i);
        rst = 1'b0;
        iv  = 1'b0;
        r   = r_i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iv  = 1'b0;
        r   = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        iv  = 1'b0;
        d   = '0;
        s   = 2'd0;
        r   = 4'b0000;
        n_vec = 0;

        //   rst iv  s  d              r      cir eir  v        full     acc y0            y1            y2            y3
        // Reset held two cycles with a push pending.
        add(1, 1, 2, 32'hFFFFFFFF, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0,        32'h0,        32'h0,        32'h0);
        add(1, 1, 2, 32'hFFFFFFFF, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 32'h0,        32'h0,        32'h0,        32'h0);
        add(0, 0, 0, 32'h0,        4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 32'h0,        32'h0,        32'h0,        32'h0);
        // Routing to each channel.
        add(0, 1, 0, 32'h11111111, 4'b0000, 1, 1, 4'b0001, 4'b0000, 1, 32'h11111111, 32'h0,        32'h0,        32'h0);
        add(0, 1, 1, 32'h22222222, 4'b0000, 1, 1, 4'b0011, 4'b0000, 1, 32'h11111111, 32'h22222222, 32'h0,        32'h0);
        add(0, 1, 2, 32'h33333333, 4'b0000, 1, 1, 4'b0111, 4'b0000, 1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0);
        add(0, 1, 3, 32'h44444444, 4'b0000, 1, 1, 4'b1111, 4'b0000, 1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        // Drain all four; heads now point at still-zero second slots.
        add(0, 0, 0, 32'h0,        4'b1111, 1, 1, 4'b0000, 4'b0000, 0, 32'h0,        32'h0,        32'h0,        32'h0);
        // Backpressure on channel 1.
        add(0, 1, 1, 32'hA0,       4'b0000, 1, 1, 4'b0010, 4'b0000, 1, 32'h0,        32'hA0,       32'h0,        32'h0);
        add(0, 1, 1, 32'hA1,       4'b0000, 1, 1, 4'b0010, 4'b0010, 1, 32'h0,        32'hA0,       32'h0,        32'h0);
        add(0, 1, 1, 32'hA2,       4'b0000, 1, 0, 4'b0010, 4'b0010, 0, 32'h0,        32'hA0,       32'h0,        32'h0);
        add(0, 1, 1, 32'hA2,       4'b0010, 1, 1, 4'b0010, 4'b0010, 1, 32'h0,        32'hA1,       32'h0,        32'h0);
        // Simultaneous push and pop on channel 3.
        add(0, 1, 3, 32'h5,        4'b0000, 1, 1, 4'b1010, 4'b0010, 1, 32'h0,        32'hA1,       32'h0,        32'h5);
        add(0, 1, 3, 32'h6,        4'b1000, 1, 1, 4'b1010, 4'b0010, 1, 32'h0,        32'hA1,       32'h0,        32'h6);
        // Idle cycle: IV=0 changes nothing.
        add(0, 0, 1, 32'h77,       4'b0000, 1, 0, 4'b1010, 4'b0010, 0, 32'h0,        32'hA1,       32'h0,        32'h6);

        for (int i = 0; i < n_vec; i++) begin
            rst = tbl[i].rst;
            iv  = tbl[i].iv;
            s   = tbl[i].s;
            d   = tbl[i].d;
            r   = tbl[i].r;
            #1;
            if (tbl[i].chk_ir) chk($sformatf("v%0d_ir", i), 32'(ir), 32'(tbl[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_v", i),    32'(v),    32'(tbl[i].e_v));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d_acc", i),  32'(acc),  32'(tbl[i].e_acc));
            chk($sformatf("v%0d_y0", i),   y0,        tbl[i].e_y0);
            chk($sformatf("v%0d_y1", i),   y1,        tbl[i].e_y1);
            chk($sformatf("v%0d_y2", i),   y2,        tbl[i].e_y2);
            chk($sformatf("v%0d_y3", i),   y3,        tbl[i].e_y3);
        end

        // Independent drain: two words per channel, interleaved pushes.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                push_word(wd(k, i), 2'(k));
            end
        end
        chk("fill_v", 32'(v), 32'hF);
        chk("fill_full", 32'(full), 32'hF);
        for (int k = 0; k < 4; k++) chk($sformatf("fill_y%0d", k), get_y(k), wd(k, 0));
        idle_cycle(4'b1111);
        chk("drain1_v", 32'(v), 32'hF);
        chk("drain1_full", 32'(full), 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("drain1_y%0d", k), get_y(k), wd(k, 1));
        idle_cycle(4'b1111);
        chk("drain2_v", 32'(v), 32'h0);
        chk("drain2_acc", 32'(acc), 32'h0);

        // Reset in the middle of a push.
        push_word(32'h0000_0C00, 2'd0);
        push_word(32'h0000_0C01, 2'd0);
        push_word(32'h0000_0C20, 2'd2);
        rst = 1'b1;
        iv  = 1'b1;
        d   = 32'hDEAD_BEEF;
        s   = 2'd1;
        r   = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv  = 1'b0;
        chk("mrst_v", 32'(v), 32'h0);
        chk("mrst_full", 32'(full), 32'h0);
        chk("mrst_acc", 32'(acc), 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("mrst_y%0d", k), get_y(k), 32'h0);
        for (int c = 0; c < 3; c++) begin
            idle_cycle(4'b1111);
            chk($sformatf("mrst_after%0d_v", c), 32'(v), 32'h0);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (get_y(k) === 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL mrst_discard_y%0d: got %h expected not deadbeef", k, get_y(k));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
